// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default raster constants and counter width shared by the VGA pipeline
package vga_timing_pkg;
    localparam int CW       = 10;
    localparam int H_DISP   = 640;
    localparam int H_FRONT  = 16;
    localparam int H_WIDTH  = 96;
    localparam int H_BACK   = 48;
    localparam int V_DISP   = 480;
    localparam int V_FRONT  = 10;
    localparam int V_WIDTH  = 2;
    localparam int V_BACK   = 33;
    localparam int H_PERIOD = H_DISP + H_FRONT + H_WIDTH + H_BACK;
    localparam int V_PERIOD = V_DISP + V_FRONT + V_WIDTH + V_BACK;
    typedef logic [CW-1:0] cnt_t;
endpackage

// File: rtl/vga_syncgen_cnt.sv
// vga_syncgen_cnt: free-running horizontal/vertical raster counter pair with wrap
module vga_syncgen_cnt
    import vga_timing_pkg::*;
#(
    parameter int HPERIOD = H_PERIOD,
    parameter int VPERIOD = V_PERIOD
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt
);
    localparam cnt_t HMAX = cnt_t'(HPERIOD - 1);
    localparam cnt_t VMAX = cnt_t'(VPERIOD - 1);
    logic hwrap;
    assign hwrap = hcnt == HMAX;
    // pixel counter every cycle; line counter steps only on the last pixel of a line
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hwrap ? '0 : hcnt + 1'b1;
            if (hwrap) vcnt <= vcnt == VMAX ? '0 : vcnt + 1'b1;
        end
endmodule

// File: rtl/vga_syncgen.sv
// vga_syncgen: VGA sync/DE/frame-start generator; colour bars when VGA_SYNCGEN_COLORBAR_EN is defined
module vga_syncgen
    import vga_timing_pkg::*;
#(
    parameter int HDISP  = H_DISP,
    parameter int HFRONT = H_FRONT,
    parameter int HWIDTH = H_WIDTH,
    parameter int HBACK  = H_BACK,
    parameter int VDISP  = V_DISP,
    parameter int VFRONT = V_FRONT,
    parameter int VWIDTH = V_WIDTH,
    parameter int VBACK  = V_BACK
) (
    input  logic          PCK,
    input  logic          RST_N,
    output logic [CW-1:0] HCNT,
    output logic [CW-1:0] VCNT,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          DE,
    output logic          FRAME_START,
    output logic [3:0]    VGA_R,
    output logic [3:0]    VGA_G,
    output logic [3:0]    VGA_B
);
    localparam int HPERIOD = HDISP + HFRONT + HWIDTH + HBACK;
    localparam int VPERIOD = VDISP + VFRONT + VWIDTH + VBACK;
    localparam int HS_ON   = HDISP + HFRONT;
    localparam int HS_OFF  = HS_ON + HWIDTH;
    localparam int VS_ON   = VDISP + VFRONT;
    localparam int VS_OFF  = VS_ON + VWIDTH;

    if (HPERIOD > (1 << CW) || VPERIOD > (1 << CW)) begin : g_period_check
        $error("vga_syncgen: raster period exceeds counter range");
    end

    vga_syncgen_cnt #(
        .HPERIOD(HPERIOD),
        .VPERIOD(VPERIOD)
    ) u_cnt (
        .clk  (PCK),
        .rst_n(RST_N),
        .hcnt (HCNT),
        .vcnt (VCNT)
    );

    int  h, v;
    logic de_next;
    assign h       = 32'(HCNT);
    assign v       = 32'(VCNT);
    assign de_next = h < HDISP && v < VDISP;

    // outputs registered from the current counter values, one PCK behind them
    always_ff @(posedge PCK or negedge RST_N)
        if (!RST_N) begin
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            DE          <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            HSYNC       <= !(h >= HS_ON && h < HS_OFF);
            VSYNC       <= !(v >= VS_ON && v < VS_OFF);
            DE          <= de_next;
            FRAME_START <= HCNT == '0 && VCNT == '0;
        end

`ifdef VGA_SYNCGEN_COLORBAR_EN
    localparam int BAR = HDISP / 8;
    logic [2:0] bar;
    assign bar = 3'(h / BAR);
    // bar colour follows the bar index bits, blanked outside the active area
    always_ff @(posedge PCK or negedge RST_N)
        if (!RST_N) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            VGA_R <= de_next ? {4{bar[2]}} : 4'h0;
            VGA_G <= de_next ? {4{bar[1]}} : 4'h0;
            VGA_B <= de_next ? {4{bar[0]}} : 4'h0;
        end
`else
    assign VGA_R = '0;
    assign VGA_G = '0;
    assign VGA_B = '0;
`endif
endmodule

// File: tb/tb_vga_syncgen.sv
// tb_vga_syncgen: directed checks of the VGA timing generator (default and reduced raster)
module tb_vga_syncgen;
    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    always #20 clk = ~clk;

    logic [9:0] hcnt, vcnt, s_hcnt, s_vcnt;
    logic       hs, vs, de, fs, s_hs, s_vs, s_de, s_fs;
    logic [3:0] r, g, b, s_r, s_g, s_b;
    logic [11:0] exp_rgb;
    int n_cmp = 0;
    int n_bad = 0;

    vga_syncgen dut (
        .PCK(clk), .RST_N(rst_n_a), .HCNT(hcnt), .VCNT(vcnt),
        .HSYNC(hs), .VSYNC(vs), .DE(de), .FRAME_START(fs),
        .VGA_R(r), .VGA_G(g), .VGA_B(b)
    );

    vga_syncgen #(
        .HDISP(16), .HFRONT(4), .HWIDTH(6), .HBACK(6),
        .VDISP(8), .VFRONT(2), .VWIDTH(3), .VBACK(3)
    ) dut_s (
        .PCK(clk), .RST_N(rst_n_b), .HCNT(s_hcnt), .VCNT(s_vcnt),
        .HSYNC(s_hs), .VSYNC(s_vs), .DE(s_de), .FRAME_START(s_fs),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        step(3);
        n_cmp++;
        if ({hcnt, vcnt, hs, vs, de, fs, r, g, b} !== {10'd0, 10'd0, 4'b1100, 12'h000}) begin
            n_bad++;
            $display("FAIL reset_state: got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b rgb=%h", hcnt, vcnt, hs, vs, de, fs, {r, g, b});
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        step(1);
        n_cmp++;
        if (hcnt !== 10'd1 || vcnt !== 10'd0) begin
            n_bad++;
            $display("FAIL first_edge_cnt: got h=%0d v=%0d want h=1 v=0", hcnt, vcnt);
        end
        n_cmp++;
        if ({fs, de, hs, vs} !== 4'b1111) begin
            n_bad++;
            $display("FAIL first_edge_out: got fs,de,hs,vs=%b want 1111", {fs, de, hs, vs});
        end
    endtask

    task automatic test_hcount();
        step(798);
        n_cmp++;
        if (hcnt !== 10'd799 || vcnt !== 10'd0) begin
            n_bad++;
            $display("FAIL hcnt_max: got h=%0d v=%0d want h=799 v=0", hcnt, vcnt);
        end
        step(1);
        n_cmp++;
        if (hcnt !== 10'd0 || vcnt !== 10'd1) begin
            n_bad++;
            $display("FAIL hcnt_wrap: got h=%0d v=%0d want h=0 v=1", hcnt, vcnt);
        end
        n_cmp++;
        if (de !== 1'b0) begin
            n_bad++;
            $display("FAIL de_blank_after_line: got %b want 0", de);
        end
    endtask

    task automatic test_hsync();
        int lo = 0;
        int act = 0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (!hs) lo++;
            if (de) act++;
            if (hcnt == 10'd656 || hcnt == 10'd657 || hcnt == 10'd752 || hcnt == 10'd753) begin
                n_cmp++;
                if (hs !== (hcnt == 10'd656 || hcnt == 10'd753)) begin
                    n_bad++;
                    $display("FAIL hsync_edge: at hcnt=%0d got hs=%b", hcnt, hs);
                end
            end
        end
        n_cmp++;
        if (lo != 96) begin
            n_bad++;
            $display("FAIL hsync_width: got %0d cycles want 96", lo);
        end
        n_cmp++;
        if (act != 640) begin
            n_bad++;
            $display("FAIL de_per_line: got %0d cycles want 640", act);
        end
    endtask

    task automatic test_colour();
        int blank_bad = 0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (!de && {r, g, b} != 12'h000) blank_bad++;
            if (hcnt == 10'd1 || hcnt == 10'd81 || hcnt == 10'd161 || hcnt == 10'd600 || hcnt == 10'd700) begin
`ifdef VGA_SYNCGEN_COLORBAR_EN
                exp_rgb = hcnt == 10'd81 ? 12'h00F : hcnt == 10'd161 ? 12'h0F0 : hcnt == 10'd600 ? 12'hFFF : 12'h000;
`else
                exp_rgb = 12'h000;
`endif
                n_cmp++;
                if ({r, g, b} !== exp_rgb) begin
                    n_bad++;
                    $display("FAIL rgb_bar: at hcnt=%0d got %h want %h", hcnt, {r, g, b}, exp_rgb);
                end
            end
        end
        n_cmp++;
        if (blank_bad != 0) begin
            n_bad++;
            $display("FAIL rgb_blank: %0d cycles nonzero with DE=0, want 0", blank_bad);
        end
    endtask

    task automatic test_small_frame();
        int vlo = 0;
        int hlo = 0;
        int act = 0;
        int fcnt = 0;
        int rgb_nz = 0;
        for (int k = 0; k < 600 && s_fs !== 1'b1; k++) step(1);
        n_cmp++;
        if (s_fs !== 1'b1) begin
            n_bad++;
            $display("FAIL small_fs_timeout: got fs=%b want 1", s_fs);
        end
        n_cmp++;
        if (s_de !== 1'b1 || s_hcnt !== 10'd1 || s_vcnt !== 10'd0) begin
            n_bad++;
            $display("FAIL small_fs_align: got de=%b h=%0d v=%0d want de=1 h=1 v=0", s_de, s_hcnt, s_vcnt);
        end
        for (int i = 0; i < 512; i++) begin
            if (!s_vs) vlo++;
            if (!s_hs) hlo++;
            if (s_de) act++;
            if (s_fs) fcnt++;
            if ({s_r, s_g, s_b} != 12'h000) rgb_nz++;
            if ((s_vcnt == 10'd10 || s_vcnt == 10'd13) && s_hcnt <= 10'd1) begin
                n_cmp++;
                if (s_vs !== ((s_vcnt == 10'd10) == (s_hcnt == 10'd0))) begin
                    n_bad++;
                    $display("FAIL small_vsync_edge: at h=%0d v=%0d got vs=%b", s_hcnt, s_vcnt, s_vs);
                end
            end
            if (i == 510 || i == 511) begin
                n_cmp++;
                if ({s_hcnt, s_vcnt} !== (i == 510 ? {10'd31, 10'd15} : 20'd0)) begin
                    n_bad++;
                    $display("FAIL small_frame_wrap: sample %0d got h=%0d v=%0d", i, s_hcnt, s_vcnt);
                end
            end
            step(1);
        end
        n_cmp++;
        if (vlo != 96 || hlo != 96 || act != 128 || fcnt != 1) begin
            n_bad++;
            $display("FAIL small_frame_counts: got vs_lo=%0d hs_lo=%0d de=%0d fs=%0d want 96 96 128 1", vlo, hlo, act, fcnt);
        end
        n_cmp++;
        if (s_fs !== 1'b1) begin
            n_bad++;
            $display("FAIL small_next_fs: got %b want 1", s_fs);
        end
`ifndef VGA_SYNCGEN_COLORBAR_EN
        n_cmp++;
        if (rgb_nz != 0) begin
            n_bad++;
            $display("FAIL rgb_off_frame: %0d nonzero cycles want 0", rgb_nz);
        end
`endif
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 600 && !(s_hcnt == 10'd20 && s_vcnt == 10'd5); k++) step(1);
        n_cmp++;
        if (s_hcnt !== 10'd20 || s_vcnt !== 10'd5) begin
            n_bad++;
            $display("FAIL mid_reset_timeout: got h=%0d v=%0d want h=20 v=5", s_hcnt, s_vcnt);
        end
        #5 rst_n_b = 1'b0;
        #1;
        n_cmp++;
        if ({s_hcnt, s_vcnt, s_hs, s_vs, s_de, s_fs, s_r, s_g, s_b} !== {10'd0, 10'd0, 4'b1100, 12'h000}) begin
            n_bad++;
            $display("FAIL async_reset: got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b", s_hcnt, s_vcnt, s_hs, s_vs, s_de, s_fs);
        end
        step(2);
        @(negedge clk);
        rst_n_b = 1'b1;
        step(1);
        n_cmp++;
        if (s_hcnt !== 10'd1 || s_vcnt !== 10'd0 || s_fs !== 1'b1 || s_de !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_restart: got h=%0d v=%0d fs=%b de=%b want 1 0 1 1", s_hcnt, s_vcnt, s_fs, s_de);
        end
        step(1);
        n_cmp++;
        if (s_fs !== 1'b0) begin
            n_bad++;
            $display("FAIL fs_single: got %b want 0", s_fs);
        end
    endtask

    initial begin
        test_reset();
        test_hcount();
        test_hsync();
        test_colour();
        test_small_frame();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
